// File: rtl/pulse_tx_sched_pkg.sv
// ------------------------------------------------------------------
// pulse_tx_sched_pkg : shared encodings for the pulse TX frame scheduler
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package pulse_tx_sched_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_LOAD = ST_LOAD,
      S_RUN  = ST_RUN,
      S_GAP  = ST_GAP
   } sched_state_e;

   localparam int DESC_START_LSB    = 0;
   localparam int DESC_START_W      = 7;
   localparam int DESC_END_LSB      = 8;
   localparam int DESC_END_W        = 7;
   localparam int DESC_LOOP_LSB     = 16;
   localparam int DESC_LOOP_W       = 8;
   localparam int DESC_LOOPBACK_LSB = 24;
   localparam int DESC_LOOPBACK_W   = 7;

   localparam logic [31:0] CFG_RESERVED_MASK = 32'h7FFF_7F7F;

   // Descriptor fields map one-to-one onto the transmitter reg_1 layout.
   function automatic logic [31:0] desc_to_cfg(input logic [31:0] desc);
      logic [31:0] cfg;
      cfg = '0;
      cfg[DESC_START_LSB    +: DESC_START_W]    = desc[DESC_START_LSB    +: DESC_START_W];
      cfg[DESC_END_LSB      +: DESC_END_W]      = desc[DESC_END_LSB      +: DESC_END_W];
      cfg[DESC_LOOP_LSB     +: DESC_LOOP_W]     = desc[DESC_LOOP_LSB     +: DESC_LOOP_W];
      cfg[DESC_LOOPBACK_LSB +: DESC_LOOPBACK_W] = desc[DESC_LOOPBACK_LSB +: DESC_LOOPBACK_W];
      return cfg & CFG_RESERVED_MASK;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_tx_frame_scheduler_if.sv
// ------------------------------------------------------------------
// pulse_tx_frame_scheduler_if : descriptor push handshake
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface pulse_tx_frame_scheduler_if;
   logic        push_valid;
   logic        push_ready;
   logic [31:0] push_desc;

   modport master (output push_valid, output push_desc, input push_ready);
   modport slave  (input push_valid, input push_desc, output push_ready);
endinterface

`default_nettype wire

// File: rtl/pulse_tx_desc_fifo.sv
// ------------------------------------------------------------------
// pulse_tx_desc_fifo : synchronous descriptor FIFO with level and flush
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pulse_tx_desc_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  wire                      clk,
   input  wire                      rst,
   input  wire                      flush,
   input  wire                      push,
   input  wire  [WIDTH-1:0]         push_data,
   input  wire                      pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             wr_en;
   logic             rd_en;

   always_comb begin
      wr_en    = push && (level_q != FULL_LVL) && !flush;
      rd_en    = pop && (level_q != '0) && !flush;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/pulse_tx_frame_scheduler.sv
// ------------------------------------------------------------------
// pulse_tx_frame_scheduler : walks queued frame descriptors through the pulse transmitter
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pulse_tx_frame_scheduler
   import pulse_tx_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GAP_W = 16
) (
   input  wire                            clk,
   input  wire                            rst,
   input  wire                            enable,
   input  wire                            abort,
   input  wire  [GAP_W-1:0]               gap_cycles,
   pulse_tx_frame_scheduler_if.slave      push_if,
   output logic [31:0]                    tx_cfg,
   output logic                           tx_run,
   input  wire                            tx_done,
   output logic                           frame_done,
   output logic                           queue_drained,
   output logic                           busy,
   output logic [$clog2(DEPTH):0]         fifo_level,
   output logic [7:0]                     frames_sent
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   sched_state_e     state_q, state_d;
   logic [31:0]      tx_cfg_q, tx_cfg_d;
   logic             tx_run_q, tx_run_d;
   logic             frame_done_q, frame_done_d;
   logic             queue_drained_q, queue_drained_d;
   logic             busy_q, busy_d;
   logic [7:0]       frames_sent_q, frames_sent_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

   logic [31:0]      fifo_head;
   logic [LVL_W-1:0] fifo_lvl;
   logic             push_ready_w;
   logic             push_accept;
   logic             pop_req;

   // Readiness comes from the registered level only, so a same-cycle pop never frees a slot early.
   assign push_ready_w     = (fifo_lvl != FULL_LVL);
   assign push_if.push_ready = push_ready_w;
   assign push_accept      = push_if.push_valid && push_ready_w;

   pulse_tx_desc_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_desc_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (abort),
      .push      (push_accept),
      .push_data (push_if.push_desc),
      .pop       (pop_req),
      .head      (fifo_head),
      .level     (fifo_lvl)
   );

   always_comb begin
      state_d         = state_q;
      tx_cfg_d        = tx_cfg_q;
      tx_run_d        = tx_run_q;
      frame_done_d    = 1'b0;
      queue_drained_d = 1'b0;
      frames_sent_d   = frames_sent_q;
      gap_cnt_d       = gap_cnt_q;
      pop_req         = 1'b0;

      if (abort) begin
         state_d   = S_IDLE;
         tx_run_d  = 1'b0;
         gap_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable && (fifo_lvl != '0)) begin
                  pop_req  = 1'b1;
                  tx_cfg_d = desc_to_cfg(fifo_head);
                  state_d  = S_LOAD;
               end
            end
            S_LOAD: begin
               tx_run_d = 1'b1;
               state_d  = S_RUN;
            end
            S_RUN: begin
               if (tx_done) begin
                  tx_run_d      = 1'b0;
                  frame_done_d  = 1'b1;
                  frames_sent_d = frames_sent_q + 8'd1;
                  // No pop can happen in RUN, so the post-frame level is just level plus any push.
                  queue_drained_d = (fifo_lvl == '0) && !push_accept;
                  if (gap_cycles != '0) begin
                     gap_cnt_d = gap_cycles;
                     state_d   = S_GAP;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt_q <= GAP_W'(1)) begin
                  gap_cnt_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q - GAP_W'(1);
               end
            end
            default: begin
               state_d  = S_IDLE;
               tx_run_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         tx_cfg_q        <= '0;
         tx_run_q        <= 1'b0;
         frame_done_q    <= 1'b0;
         queue_drained_q <= 1'b0;
         busy_q          <= 1'b0;
         frames_sent_q   <= '0;
         gap_cnt_q       <= '0;
      end else begin
         state_q         <= state_d;
         tx_cfg_q        <= tx_cfg_d;
         tx_run_q        <= tx_run_d;
         frame_done_q    <= frame_done_d;
         queue_drained_q <= queue_drained_d;
         busy_q          <= busy_d;
         frames_sent_q   <= frames_sent_d;
         gap_cnt_q       <= gap_cnt_d;
      end
   end

   assign tx_cfg        = tx_cfg_q;
   assign tx_run        = tx_run_q;
   assign frame_done    = frame_done_q;
   assign queue_drained = queue_drained_q;
   assign busy          = busy_q;
   assign fifo_level    = fifo_lvl;
   assign frames_sent   = frames_sent_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_tx_frame_scheduler.sv
// ------------------------------------------------------------------
// tb_pulse_tx_frame_scheduler : randomized directed bench with a queue-based reference model
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pulse_tx_frame_scheduler;

   localparam int          DEPTH = 4;
   localparam int          GAP_W = 16;
   localparam logic [31:0] KEEP  = 32'h7FFF_7F7F;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b0;
   logic             abort = 1'b0;
   logic             tx_done = 1'b0;
   logic [GAP_W-1:0] gap_cycles = '0;
   logic [31:0]      tx_cfg;
   logic             tx_run;
   logic             frame_done;
   logic             queue_drained;
   logic             busy;
   logic [2:0]       fifo_level;
   logic [7:0]       frames_sent;

   pulse_tx_frame_scheduler_if push_if();

   pulse_tx_frame_scheduler #(
      .DEPTH (DEPTH),
      .GAP_W (GAP_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .abort         (abort),
      .gap_cycles    (gap_cycles),
      .push_if       (push_if),
      .tx_cfg        (tx_cfg),
      .tx_run        (tx_run),
      .tx_done       (tx_done),
      .frame_done    (frame_done),
      .queue_drained (queue_drained),
      .busy          (busy),
      .fifo_level    (fifo_level),
      .frames_sent   (frames_sent)
   );

   always #5 clk = ~clk;

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] model_q[$];
   int          exp_sent   = 0;
   logic [31:0] cur_cfg    = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_tx_cfg"},        tx_cfg,        32'h0);
      chk({tag, "_tx_run"},        tx_run,        32'h0);
      chk({tag, "_frame_done"},    frame_done,    32'h0);
      chk({tag, "_queue_drained"}, queue_drained, 32'h0);
      chk({tag, "_busy"},          busy,          32'h0);
      chk({tag, "_fifo_level"},    fifo_level,    32'h0);
      chk({tag, "_frames_sent"},   frames_sent,   32'h0);
      chk({tag, "_push_ready"},    push_if.push_ready, 32'h1);
   endtask

   // Offer one descriptor for one cycle; the model accepts it only if it has room.
   task automatic push(input logic [31:0] d);
      push_if.push_valid = 1'b1;
      push_if.push_desc  = d;
      chk("push_ready", push_if.push_ready, (model_q.size() < DEPTH) ? 32'h1 : 32'h0);
      @(negedge clk);
      if (model_q.size() < DEPTH) model_q.push_back(d);
      push_if.push_valid = 1'b0;
   endtask

   // Wait for tx_run to rise; the launched config must be the oldest queued descriptor.
   task automatic wait_run(output int n);
      logic [31:0] d;
      n = 0;
      while (tx_run !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("run_rise", tx_run, 32'h1);
      if (model_q.size() > 0) begin
         d       = model_q.pop_front();
         cur_cfg = d & KEEP;
         chk("tx_cfg", tx_cfg, cur_cfg);
      end
   endtask

   // Complete the running frame; optionally measure the low time until the next frame starts.
   task automatic finish_frame(input bit measure, input int gap);
      int lows;
      repeat ($urandom_range(0, 3)) begin
         @(negedge clk);
         chk("cfg_stable", tx_cfg, cur_cfg);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done  = 1'b0;
      exp_sent = (exp_sent + 1) % 256;
      chk("run_low_after_done", tx_run,        32'h0);
      chk("frame_done",         frame_done,    32'h1);
      chk("frames_sent",        frames_sent,   32'(exp_sent));
      chk("queue_drained",      queue_drained, (model_q.size() == 0) ? 32'h1 : 32'h0);
      if (measure) begin
         lows = 1;
         while (lows < gap + 20) begin
            @(negedge clk);
            if (tx_run === 1'b1) break;
            lows++;
         end
         chk("gap_low_cycles", 32'(lows), 32'(gap + 2));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      int k;
      push_if.push_valid = 1'b0;
      push_if.push_desc  = '0;

      repeat (3) @(negedge clk);
      check_reset("in_rst");
      rst = 1'b0;
      @(negedge clk);
      check_reset("after_rst");

      // Single frame: launch latency and completion.
      enable     = 1'b1;
      gap_cycles = '0;
      push(32'h0003_0A00);
      wait_run(n);
      chk("launch_latency", 32'(n + 1), 32'd3);
      chk("busy_run", busy, 32'h1);
      finish_frame(1'b0, 0);

      // Three queued frames with gap 5.
      enable     = 1'b0;
      gap_cycles = 16'd5;
      @(negedge clk);
      repeat (3) push($urandom());
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_run(n);
         finish_frame(i < 2, 5);
      end

      // Fill the FIFO while disabled, refuse a fifth push, then drain in order.
      enable     = 1'b0;
      gap_cycles = '0;
      repeat (4) push($urandom());
      chk("full_level", fifo_level, 32'd4);
      chk("full_ready", push_if.push_ready, 32'h0);
      push($urandom());
      chk("full_level_after_refuse", fifo_level, 32'd4);
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_run(n);
         finish_frame(i < 3, 0);
      end

      // Abort during RUN coincident with tx_done, two entries queued.
      enable = 1'b0;
      @(negedge clk);
      repeat (3) push($urandom());
      enable = 1'b1;
      wait_run(n);
      chk("abort_pre_level", fifo_level, 32'd2);
      abort   = 1'b1;
      tx_done = 1'b1;
      @(negedge clk);
      abort   = 1'b0;
      tx_done = 1'b0;
      model_q.delete();
      chk("abort_tx_run",      tx_run,        32'h0);
      chk("abort_level",       fifo_level,    32'h0);
      chk("abort_frame_done",  frame_done,    32'h0);
      chk("abort_drained",     queue_drained, 32'h0);
      chk("abort_frames_sent", frames_sent,   32'(exp_sent));
      chk("abort_busy",        busy,          32'h0);
      @(negedge clk);
      chk("abort_hold_run",    tx_run,        32'h0);
      // Push in the abort cycle is dropped.
      push_if.push_valid = 1'b1;
      push_if.push_desc  = $urandom();
      abort              = 1'b1;
      @(negedge clk);
      push_if.push_valid = 1'b0;
      abort              = 1'b0;
      chk("abort_push_dropped", fifo_level, 32'h0);

      // Disable mid-frame: frame finishes, block holds with one entry left.
      enable = 1'b0;
      @(negedge clk);
      repeat (2) push($urandom());
      enable = 1'b1;
      wait_run(n);
      enable = 1'b0;
      finish_frame(1'b0, 0);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      @(negedge clk);
      chk("idle_done_ignored",   frame_done,  32'h0);
      chk("idle_done_sent",      frames_sent, 32'(exp_sent));
      repeat (5) @(negedge clk);
      chk("hold_tx_run", tx_run,     32'h0);
      chk("hold_busy",   busy,       32'h0);
      chk("hold_level",  fifo_level, 32'd1);
      enable = 1'b1;
      wait_run(n);
      finish_frame(1'b0, 0);

      // Keep one frame queued ahead with random gaps until frames_sent wraps to 0.
      k = 256 - exp_sent;
      push($urandom());
      for (int i = 0; i < k; i++) begin
         if (i < k - 1) push($urandom());
         wait_run(n);
         gap_cycles = 16'($urandom_range(0, 3));
         finish_frame(i < k - 1, int'(gap_cycles));
      end
      chk("frames_wrap", frames_sent, 32'h0);

      // Reset in the middle of a long gap.
      gap_cycles = 16'd20;
      push($urandom());
      wait_run(n);
      finish_frame(1'b0, 20);
      @(negedge clk);
      chk("gap_busy", busy, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_q.delete();
      exp_sent = 0;
      check_reset("rst_mid_gap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
